// File: rtl/lane_linear_axil_pkg.sv
// Shared types and constants for the lane_linear AXI4-Lite register bank.
package lane_linear_axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  // Word address starts at this byte-address bit.
  localparam int ADDR_LSB = 2;

  // Register slots in the bank, by word index.
  localparam int REG_IDX_0 = 0;
  localparam int REG_IDX_1 = 1;
  localparam int REG_IDX_2 = 2;
  localparam int REG_IDX_3 = 3;

endpackage

// File: rtl/lane_linear_axil_regs.sv
// AXI4-Lite register bank for the lane_linear datapath: independent AW/W
// capture with a single outstanding write, 1-cycle registered reads.
module lane_linear_axil_regs
  import lane_linear_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  wstate_t           wstate_q, wstate_d;
  logic [IDX_W-1:0]  awidx_q, awidx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  axi_resp_t         bresp_q, bresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  rstate_t           rstate_q, rstate_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  axi_resp_t         rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  cidx, aridx;
  logic [DATA_W-1:0] cdata;
  logic [STRB_W-1:0] cstrb;
  logic              unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign S_AXI_AWREADY = S_AXI_ARESETN && (wstate_q == W_IDLE || wstate_q == W_HAVE_W);
  assign S_AXI_WREADY  = S_AXI_ARESETN && (wstate_q == W_IDLE || wstate_q == W_HAVE_AW);
  assign S_AXI_ARREADY = S_AXI_ARESETN && (rstate_q == R_IDLE);
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign S_AXI_BVALID = (wstate_q == W_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (rstate_q == R_RESP);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign reg_wr_pulse = pulse_q;

  // A commit takes whichever half is already latched and the other half live from the bus.
  assign cidx  = (wstate_q == W_HAVE_AW) ? awidx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign cdata = (wstate_q == W_HAVE_W)  ? wdata_q : S_AXI_WDATA;
  assign cstrb = (wstate_q == W_HAVE_W)  ? wstrb_q : S_AXI_WSTRB;
  assign aridx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  // Flatten the register array onto the datapath bus.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[DATA_W*i +: DATA_W] = regs_q[i];
  end

  // Write FSM: collect AW and W in any order, commit with byte strobes, hold B until accepted.
  always_comb begin
    wstate_d = wstate_q;
    awidx_d  = awidx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    pulse_d  = '0;
    regs_d   = regs_q;
    commit   = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awidx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs)  commit = 1'b1;
      W_HAVE_W:  if (aw_hs) commit = 1'b1;
      W_RESP:    if (S_AXI_BREADY) wstate_d = W_IDLE;
      default:   wstate_d = W_IDLE;
    endcase
    if (commit) begin
      wstate_d = W_RESP;
      bresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(cidx) == i) begin
          bresp_d    = RESP_OKAY;
          pulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (cstrb[k]) regs_d[i][8*k +: 8] = cdata[8*k +: 8];
          end
        end
      end
    end
  end

  // Read FSM: capture the addressed register on the AR handshake, hold R until accepted.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_RESP;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(aridx) == i) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      R_RESP:  if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // State, register bank and response registers; reset drops any half-collected write.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wstate_q <= W_IDLE;
      bresp_q  <= RESP_OKAY;
      pulse_q  <= '0;
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      bresp_q  <= bresp_d;
      pulse_q  <= pulse_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Write-side holding registers; only meaningful while the write FSM says they are held.
  always_ff @(posedge S_AXI_ACLK) begin
    awidx_q <= awidx_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

endmodule

// File: tb/tb_lane_linear_axil_regs.sv
// Scoreboard bench for lane_linear_axil_regs: drivers queue expected B/R
// responses, a monitor pops and compares on every response handshake.
module tb_lane_linear_axil_regs;
  import lane_linear_axil_pkg::*;

  localparam logic [4:0] A0 = 5'(REG_IDX_0 << ADDR_LSB);
  localparam logic [4:0] A1 = 5'(REG_IDX_1 << ADDR_LSB);
  localparam logic [4:0] A2 = 5'(REG_IDX_2 << ADDR_LSB);
  localparam logic [4:0] A3 = 5'(REG_IDX_3 << ADDR_LSB);
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic         clk;
  logic         ARESETN;
  logic [4:0]   AWADDR, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] bq [$];
  rexp_t      rq [$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] eb;
  rexp_t      er;

  lane_linear_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted response against the head of its queue.
  always @(negedge clk) begin
    if (ARESETN && BVALID && BREADY) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL bresp_unexpected: got 0x%0h required no response", BRESP);
      end else begin
        eb = bq.pop_front();
        chk("bresp", {126'b0, BRESP}, {126'b0, eb});
      end
    end
    if (ARESETN && RVALID && RREADY) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got 0x%0h required no response", RDATA);
      end else begin
        er = rq.pop_front();
        chk("rdata", {96'b0, RDATA}, {96'b0, er.d});
        chk("rresp", {126'b0, RRESP}, {126'b0, er.r});
      end
    end
  end

  task automatic dly(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("bvalid_early", {127'b0, BVALID}, 128'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_aw(input logic [4:0] a);
    int n = 0;
    AWADDR = a; AWVALID = 1'b1;
    @(negedge clk);
    while (!AWREADY && n < 20) begin @(negedge clk); n++; end
    chk("aw_handshake", {127'b0, AWREADY}, 128'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    @(negedge clk);
    while (!WREADY && n < 20) begin @(negedge clk); n++; end
    chk("w_handshake", {127'b0, WREADY}, 128'd1);
    @(posedge clk); #1;
    WVALID = 1'b0;
  endtask

  // Called right after the commit edge: B and pulse must appear at once, pulse lasts one cycle.
  task automatic finish_write(input logic [3:0] pl);
    int n = 0;
    @(negedge clk);
    chk("bvalid_latency", {127'b0, BVALID}, 128'd1);
    chk("wr_pulse", {124'b0, reg_wr_pulse}, {124'b0, pl});
    while (!(BVALID && BREADY) && n < 20) begin @(negedge clk); n++; end
    chk("b_handshake", {127'b0, BVALID && BREADY}, 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_pulse_clear", {124'b0, reg_wr_pulse}, 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] resp);
    logic [3:0] pl;
    pl = (resp == OK) ? (4'b0001 << a[4:2]) : 4'b0000;
    bq.push_back(resp);
    fork
      begin dly(aw_dly); send_aw(a); end
      begin dly(w_dly);  send_w(d, s); end
    join
    finish_write(pl);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n = 0;
    rq.push_back(rexp_t'{d: d, r: resp});
    ARADDR = a; ARVALID = 1'b1;
    @(negedge clk);
    while (!ARREADY && n < 20) begin @(negedge clk); n++; end
    chk("ar_handshake", {127'b0, ARREADY}, 128'd1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    @(negedge clk);
    chk("rvalid_latency", {127'b0, RVALID}, 128'd1);
    n = 0;
    while (!(RVALID && RREADY) && n < 20) begin @(negedge clk); n++; end
    chk("r_handshake", {127'b0, RVALID && RREADY}, 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    ARESETN = 1'b0; AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {127'b0, AWREADY}, 128'd0);
    chk("rst_wready",  {127'b0, WREADY},  128'd0);
    chk("rst_arready", {127'b0, ARREADY}, 128'd0);
    chk("rst_bvalid",  {127'b0, BVALID},  128'd0);
    chk("rst_rvalid",  {127'b0, RVALID},  128'd0);
    chk("rst_rdata",   {96'b0, RDATA},    128'd0);
    chk("rst_resps",   {124'b0, BRESP, RRESP}, 128'd0);
    chk("rst_reg_q",   reg_q,             128'd0);
    chk("rst_pulse",   {124'b0, reg_wr_pulse}, 128'd0);
    @(posedge clk); #1;
    ARESETN = 1'b1;
    @(negedge clk);
    chk("idle_readies", {125'b0, AWREADY, WREADY, ARREADY}, 128'd7);
    @(posedge clk); #1;

    // Sequential write then read
    do_write(A0, 32'h1, 4'hF, 0, 0, OK);
    do_write(A1, 32'h2, 4'hF, 0, 0, OK);
    do_write(A2, 32'h3, 4'hF, 0, 0, OK);
    do_write(A3, 32'h4, 4'hF, 0, 0, OK);
    chk("reg_q_flat", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});
    do_read(A0, 32'h1, OK);
    do_read(A1, 32'h2, OK);
    do_read(A2, 32'h3, OK);
    do_read(A3, 32'h4, OK);

    // AW three cycles before W, then W two cycles before AW
    do_write(A2, 32'hA5, 4'hF, 0, 3, OK);
    do_write(A3, 32'h5A, 4'hF, 2, 0, OK);
    do_read(A2, 32'hA5, OK);
    do_read(A3, 32'h5A, OK);

    // Byte strobes over 0x11223344
    do_write(A0, 32'h11223344, 4'hF, 0, 0, OK);
    do_write(A0, 32'hAABBCCDD, 4'b0101, 0, 0, OK);
    do_read(A0, 32'h11BB33DD, OK);
    do_write(A0, 32'h11223344, 4'hF, 0, 0, OK);
    do_write(A0, 32'hAABBCCDD, 4'b0100, 0, 0, OK);
    do_read(A0, 32'h11BB3344, OK);

    // Out-of-range write and read
    do_write(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, SE);
    chk("slverr_reg_q", reg_q, {32'h5A, 32'hA5, 32'h2, 32'h11BB3344});
    do_read(A0, 32'h11BB3344, OK);
    do_read(A1, 32'h2, OK);
    do_read(5'h18, 32'h0, SE);

    // B held for 5 cycles with BREADY low
    BREADY = 1'b0;
    fork
      do_write(A2, 32'hCAFEF00D, 4'hF, 0, 0, OK);
      begin
        int n = 0;
        @(negedge clk);
        while (!BVALID && n < 20) begin @(negedge clk); n++; end
        repeat (5) begin
          @(negedge clk);
          chk("bstall_bvalid", {127'b0, BVALID}, 128'd1);
          chk("bstall_bresp",  {126'b0, BRESP}, {126'b0, OK});
          chk("bstall_readies", {126'b0, AWREADY, WREADY}, 128'd0);
        end
        @(posedge clk); #1;
        BREADY = 1'b1;
      end
    join

    // R held for 5 cycles with RREADY low
    RREADY = 1'b0;
    fork
      do_read(A2, 32'hCAFEF00D, OK);
      begin
        int n = 0;
        @(negedge clk);
        while (!RVALID && n < 20) begin @(negedge clk); n++; end
        repeat (5) begin
          @(negedge clk);
          chk("rstall_rvalid",  {127'b0, RVALID}, 128'd1);
          chk("rstall_rdata",   {96'b0, RDATA}, 128'hCAFEF00D);
          chk("rstall_rresp",   {126'b0, RRESP}, {126'b0, OK});
          chk("rstall_arready", {127'b0, ARREADY}, 128'd0);
        end
        @(posedge clk); #1;
        RREADY = 1'b1;
      end
    join

    // Same-edge write and read of reg 1: read sees the old value
    fork
      do_write(A1, 32'h55, 4'hF, 0, 0, OK);
      do_read(A1, 32'h2, OK);
    join
    do_read(A1, 32'h55, OK);

    // Reset while W is latched: the W is dropped and registers clear
    send_w(32'hDEADBEEF, 4'hF);
    ARESETN = 1'b0;
    @(negedge clk);
    chk("midrst_readies", {125'b0, AWREADY, WREADY, ARREADY}, 128'd0);
    @(posedge clk); #1;
    ARESETN = 1'b1;
    @(negedge clk);
    chk("midrst_bvalid", {127'b0, BVALID}, 128'd0);
    chk("midrst_reg_q", reg_q, 128'd0);
    @(posedge clk); #1;
    send_aw(A0);
    dly(3);
    bq.push_back(OK);
    send_w(32'h77, 4'hF);
    finish_write(4'b0001);
    do_read(A0, 32'h77, OK);
    do_read(A1, 32'h0, OK);

    repeat (3) @(posedge clk);
    chk("bq_drained", 128'(bq.size()), 128'd0);
    chk("rq_drained", 128'(rq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
